vga_frame_monitor: RTL and testbench

- Receive-side counterpart of the VGA timing controller. It samples the same `hSync_n`, `vSync_n`, `blank_n` and 24-bit RGB stream that drives the DAC.
- It recovers pixel coordinates, measures line and frame periods, and locks onto the nominal 800x600 timing (1040x666 clocks per frame).
- Per frame it reports an additive RGB checksum and a lit-pixel count.
- It sits alongside the top-level pixel mux, so a bench or on-chip checker can verify drawn objects without an external monitor.

---
 rtl/vga_frame_monitor.sv | 267 ++++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_monitor
// Brief    : Receive-side VGA timing checker. Recovers pixel coordinates,
//            measures line/frame periods, locks onto nominal timing and
//            reports a per-frame additive RGB checksum and lit-pixel count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_monitor #(
    parameter int H_TOTAL = 1040,
    parameter int V_TOTAL = 666
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        hSync_n,
    input  logic        vSync_n,
    input  logic        blank_n,
    input  logic [23:0] pixelIn,
    output logic        pixelValid,
    output logic [23:0] pixelOut,
    output logic [11:0] xPos,
    output logic [11:0] yPos,
    output logic [11:0] lineLength,
    output logic [11:0] frameLines,
    output logic        hError,
    output logic        vError,
    output logic        frameDone,
    output logic [31:0] frameChecksum,
    output logic [19:0] litCount,
    output logic        locked
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [12:0] H_TOTAL_W = 13'(H_TOTAL);
    localparam logic [12:0] V_TOTAL_W = 13'(V_TOTAL);

    // Input sample stage and previous-sample stage
    logic        hs_s_q, hs_s_d, vs_s_q, vs_s_d, bl_s_q, bl_s_d;
    logic [23:0] pix_s_q, pix_s_d;
    logic        hs_p_q, hs_p_d, vs_p_q, vs_p_d, bl_p_q, bl_p_d;
    // Registered edge flags and aligned pixel
    logic        hfall_q, hfall_d, vfall_q, vfall_d, bfall_q, bfall_d;
    logic        act_q, act_d;
    logic [23:0] pix_a_q, pix_a_d;
    // Coordinate recovery
    logic [11:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic [23:0] pixel_out_q, pixel_out_d;
    logic [11:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    // Period measurement
    logic [11:0] h_cnt_q, h_cnt_d, line_cnt_q, line_cnt_d;
    logic [11:0] line_length_q, line_length_d, frame_lines_q, frame_lines_d;
    logic        h_error_q, h_error_d, v_error_q, v_error_d;
    // Frame statistics
    logic [31:0] acc_q, acc_d, checksum_q, checksum_d;
    logic [19:0] lit_q, lit_d, lit_count_q, lit_count_d;
    logic        frame_done_q, frame_done_d;
    // Lock FSM
    state_t      state_q, state_d;
    logic        bad_q, bad_d;

    logic [12:0] meas_len;
    logic [11:0] line_inc, line_eff;
    logic        h_err, v_err;
    logic [31:0] pix_add;
    logic [19:0] lit_add;

    // Measured period of the line that just ended; line count including a coincident hFall
    assign meas_len = {1'b0, h_cnt_q} + 13'd1;
    assign line_inc = (line_cnt_q == 12'hFFF) ? line_cnt_q : line_cnt_q + 12'd1;
    assign line_eff = hfall_q ? line_inc : line_cnt_q;
    assign h_err    = hfall_q && (state_q != ST_SEARCH) && (meas_len != H_TOTAL_W);
    assign v_err    = vfall_q && (state_q != ST_SEARCH) && ({1'b0, line_eff} != V_TOTAL_W);
    assign pix_add  = act_q ? {8'd0, pix_a_q} : 32'd0;
    assign lit_add  = (act_q && (pix_a_q != 24'd0)) ? 20'd1 : 20'd0;

    // Input sampling and falling-edge detection
    always_comb begin
        hs_s_d  = hSync_n;
        vs_s_d  = vSync_n;
        bl_s_d  = blank_n;
        pix_s_d = pixelIn;
        hs_p_d  = hs_s_q;
        vs_p_d  = vs_s_q;
        bl_p_d  = bl_s_q;
        hfall_d = hs_p_q & ~hs_s_q;
        vfall_d = vs_p_q & ~vs_s_q;
        bfall_d = bl_p_q & ~bl_s_q;
        act_d   = bl_s_q;
        pix_a_d = pix_s_q;
    end

    // Lock FSM next-state logic
    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        case (state_q)
            ST_SEARCH: begin
                if (vfall_q) begin
                    state_d = ST_MEASURE;
                    bad_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (h_err) begin
                    bad_d = 1'b1;
                end
                if (vfall_q) begin
                    bad_d = 1'b0;
                    if (!bad_q && !h_err && !v_err) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_err || v_err) begin
                    state_d = ST_SEARCH;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                bad_d   = 1'b0;
            end
        endcase
    end

    // Coordinates, period measurement and frame statistics
    always_comb begin
        pixel_valid_d = act_q;
        pixel_out_d   = pixel_out_q;
        x_pos_d       = x_pos_q;
        y_pos_d       = y_pos_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        if (act_q) begin
            pixel_out_d = pix_a_q;
            x_pos_d     = x_cnt_q;
            y_pos_d     = y_cnt_q;
            x_cnt_d     = x_cnt_q + 12'd1;
        end
        if (bfall_q) begin
            x_cnt_d = 12'd0;
            y_cnt_d = y_cnt_q + 12'd1;
        end
        if (vfall_q) begin
            x_cnt_d = 12'd0;
            y_cnt_d = 12'd0;
        end

        h_cnt_d       = hfall_q ? 12'd0 : ((h_cnt_q == 12'hFFF) ? h_cnt_q : h_cnt_q + 12'd1);
        line_length_d = line_length_q;
        if (hfall_q) begin
            line_length_d = meas_len[12] ? 12'hFFF : meas_len[11:0];
        end
        line_cnt_d    = vfall_q ? 12'd0 : line_eff;
        frame_lines_d = vfall_q ? line_eff : frame_lines_q;
        h_error_d     = h_err;
        v_error_d     = v_err;

        checksum_d    = checksum_q;
        lit_count_d   = lit_count_q;
        frame_done_d  = 1'b0;
        if (state_q == ST_SEARCH) begin
            // Statistics only start counting at the vFall that leaves SEARCH
            acc_d = vfall_q ? pix_add : 32'd0;
            lit_d = vfall_q ? lit_add : 20'd0;
        end else if (vfall_q) begin
            checksum_d   = acc_q;
            lit_count_d  = lit_q;
            frame_done_d = 1'b1;
            acc_d        = pix_add;
            lit_d        = lit_add;
        end else begin
            acc_d = acc_q + pix_add;
            lit_d = (lit_q == 20'hFFFFF) ? lit_q : lit_q + lit_add;
        end
    end

    // State registers; sync samples reset high so releasing Reset cannot fake an edge
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hs_s_q        <= 1'b1;
            vs_s_q        <= 1'b1;
            bl_s_q        <= 1'b1;
            pix_s_q       <= 24'd0;
            hs_p_q        <= 1'b1;
            vs_p_q        <= 1'b1;
            bl_p_q        <= 1'b1;
            hfall_q       <= 1'b0;
            vfall_q       <= 1'b0;
            bfall_q       <= 1'b0;
            act_q         <= 1'b0;
            pix_a_q       <= 24'd0;
            x_cnt_q       <= 12'd0;
            y_cnt_q       <= 12'd0;
            pixel_valid_q <= 1'b0;
            pixel_out_q   <= 24'd0;
            x_pos_q       <= 12'd0;
            y_pos_q       <= 12'd0;
            h_cnt_q       <= 12'd0;
            line_cnt_q    <= 12'd0;
            line_length_q <= 12'd0;
            frame_lines_q <= 12'd0;
            h_error_q     <= 1'b0;
            v_error_q     <= 1'b0;
            acc_q         <= 32'd0;
            lit_q         <= 20'd0;
            checksum_q    <= 32'd0;
            lit_count_q   <= 20'd0;
            frame_done_q  <= 1'b0;
            state_q       <= ST_SEARCH;
            bad_q         <= 1'b0;
        end else begin
            hs_s_q        <= hs_s_d;
            vs_s_q        <= vs_s_d;
            bl_s_q        <= bl_s_d;
            pix_s_q       <= pix_s_d;
            hs_p_q        <= hs_p_d;
            vs_p_q        <= vs_p_d;
            bl_p_q        <= bl_p_d;
            hfall_q       <= hfall_d;
            vfall_q       <= vfall_d;
            bfall_q       <= bfall_d;
            act_q         <= act_d;
            pix_a_q       <= pix_a_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_out_q   <= pixel_out_d;
            x_pos_q       <= x_pos_d;
            y_pos_q       <= y_pos_d;
            h_cnt_q       <= h_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_length_q <= line_length_d;
            frame_lines_q <= frame_lines_d;
            h_error_q     <= h_error_d;
            v_error_q     <= v_error_d;
            acc_q         <= acc_d;
            lit_q         <= lit_d;
            checksum_q    <= checksum_d;
            lit_count_q   <= lit_count_d;
            frame_done_q  <= frame_done_d;
            state_q       <= state_d;
            bad_q         <= bad_d;
        end
    end

    assign pixelValid    = pixel_valid_q;
    assign pixelOut      = pixel_out_q;
    assign xPos          = x_pos_q;
    assign yPos          = y_pos_q;
    assign lineLength    = line_length_q;
    assign frameLines    = frame_lines_q;
    assign hError        = h_error_q;
    assign vError        = v_error_q;
    assign frameDone     = frame_done_q;
    assign frameChecksum = checksum_q;
    assign litCount      = lit_count_q;
    assign locked        = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_monitor
// Brief    : Scoreboard bench for vga_frame_monitor on a reduced 64x24 raster
//            (40x16 active). The driver pushes expected pixels and pulse
//            events; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_monitor;

    localparam int H_TOT = 64;
    localparam int V_TOT = 24;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        hSync_n, vSync_n, blank_n;
    logic [23:0] pixelIn;
    logic        pixelValid;
    logic [23:0] pixelOut;
    logic [11:0] xPos, yPos, lineLength, frameLines;
    logic        hError, vError, frameDone;
    logic [31:0] frameChecksum;
    logic [19:0] litCount;
    logic        locked;

    vga_frame_monitor #(.H_TOTAL(H_TOT), .V_TOTAL(V_TOT)) dut (
        .Clock(Clock), .Reset(Reset), .hSync_n(hSync_n), .vSync_n(vSync_n),
        .blank_n(blank_n), .pixelIn(pixelIn), .pixelValid(pixelValid),
        .pixelOut(pixelOut), .xPos(xPos), .yPos(yPos), .lineLength(lineLength),
        .frameLines(frameLines), .hError(hError), .vError(vError),
        .frameDone(frameDone), .frameChecksum(frameChecksum),
        .litCount(litCount), .locked(locked)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          e;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] p;
    } pix_exp_t;

    typedef struct {
        int          e;
        bit          done;
        bit          herr;
        bit          verr;
        bit          lk;
        bit          stats;
        logic [31:0] chk;
        logic [19:0] lit;
        logic [11:0] llen;
        logic [11:0] flines;
    } ev_exp_t;

    pix_exp_t pq[$];
    ev_exp_t  eq[$];
    pix_exp_t pe;
    ev_exp_t  ev;
    int       total = 0;
    int       bad = 0;
    int       edge_cnt = 0;
    bit       pix_track = 1'b0;
    bit       lk_exp = 1'b0;

    always @(posedge Clock) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: compare pulses and pixels against the queued expectations
    always @(negedge Clock) begin
        if (!Reset) begin
            while (eq.size() > 0 && eq[0].e < edge_cnt) begin
                ev = eq.pop_front();
                check("event_missing_edge", 32'(edge_cnt), 32'(ev.e));
            end
            if (frameDone || hError || vError) begin
                if (eq.size() == 0) begin
                    check("unexpected_event", {29'd0, frameDone, hError, vError}, 32'd0);
                end else begin
                    ev = eq.pop_front();
                    check("event_edge", 32'(edge_cnt), 32'(ev.e));
                    check("frameDone", 32'(frameDone), 32'(ev.done));
                    check("hError", 32'(hError), 32'(ev.herr));
                    check("vError", 32'(vError), 32'(ev.verr));
                    check("locked_at_event", 32'(locked), 32'(ev.lk));
                    check("lineLength", 32'(lineLength), 32'(ev.llen));
                    if (ev.stats) begin
                        check("frameChecksum", frameChecksum, ev.chk);
                        check("litCount", 32'(litCount), 32'(ev.lit));
                        check("frameLines", 32'(frameLines), 32'(ev.flines));
                    end
                    lk_exp = ev.lk;
                end
            end else begin
                check("locked_steady", 32'(locked), 32'(lk_exp));
            end
            if (pix_track) begin
                while (pq.size() > 0 && pq[0].e < edge_cnt) begin
                    pe = pq.pop_front();
                    check("pixel_missing_edge", 32'(edge_cnt), 32'(pe.e));
                end
                if (pixelValid) begin
                    if (pq.size() == 0) begin
                        check("unexpected_pixel", 32'(pixelValid), 32'd0);
                    end else begin
                        pe = pq.pop_front();
                        check("pixel_edge", 32'(edge_cnt), 32'(pe.e));
                        check("pixelOut", 32'(pixelOut), 32'(pe.p));
                        check("xPos", 32'(xPos), 32'(pe.x));
                        check("yPos", 32'(yPos), 32'(pe.y));
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_pixelValid"}, 32'(pixelValid), 32'd0);
        check({tag, "_pixelOut"}, 32'(pixelOut), 32'd0);
        check({tag, "_xPos"}, 32'(xPos), 32'd0);
        check({tag, "_yPos"}, 32'(yPos), 32'd0);
        check({tag, "_lineLength"}, 32'(lineLength), 32'd0);
        check({tag, "_frameLines"}, 32'(frameLines), 32'd0);
        check({tag, "_errors"}, {30'd0, hError, vError}, 32'd0);
        check({tag, "_frameDone"}, 32'(frameDone), 32'd0);
        check({tag, "_frameChecksum"}, frameChecksum, 32'd0);
        check({tag, "_litCount"}, 32'(litCount), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    // One clock of stimulus; active pixels are queued with their due edge
    task automatic drive(input logic hs, input logic vs, input logic bl,
                         input logic [23:0] px, input int x, input int y);
        @(posedge Clock);
        #1;
        hSync_n = hs;
        vSync_n = vs;
        blank_n = bl;
        pixelIn = px;
        if (bl && pix_track && !Reset)
            pq.push_back('{e: edge_cnt + 3, x: 12'(x), y: 12'(y), p: px});
    endtask

    task automatic push_ev(input bit done, input bit herr, input bit verr, input bit lk,
                           input bit stats, input logic [31:0] chk, input logic [19:0] lit,
                           input logic [11:0] llen, input logic [11:0] flines);
        eq.push_back('{e: edge_cnt + 3, done: done, herr: herr, verr: verr, lk: lk,
                       stats: stats, chk: chk, lit: lit, llen: llen, flines: flines});
    endtask

    // One frame: hsync low for 8 clocks, vsync low for lines 0-3,
    // active area lines 6-21 x clocks 16-55. mode 0 black, 1 5x5 white at (10,5), 2 white.
    // ev* describe the pulse expected at this frame's opening vFall.
    task automatic send_frame(input int nlines, input int short_line, input int mode,
                              input int rst_line, input bit ev_on, input bit ev_verr,
                              input bit ev_lk, input logic [31:0] chk,
                              input logic [19:0] lit, input int flines);
        pix_track = 1'b1;
        for (int ln = 0; ln < nlines; ln++) begin
            int len;
            len = (ln == short_line) ? H_TOT - 1 : H_TOT;
            for (int c = 0; c < len; c++) begin
                bit          act;
                int          x;
                int          y;
                logic [23:0] px;
                act = (ln >= 6) && (ln < 22) && (c >= 16) && (c < 56);
                x   = c - 16;
                y   = ln - 6;
                px  = 24'd0;
                if (act && mode == 2) px = 24'hFFFFFF;
                if (act && mode == 1 && x >= 10 && x < 15 && y >= 5 && y < 10) px = 24'hFFFFFF;
                drive((c < 8) ? 1'b0 : 1'b1, (ln < 4) ? 1'b0 : 1'b1, act, px, x, y);
                if (ln == 0 && c == 0 && ev_on)
                    push_ev(1'b1, 1'b0, ev_verr, ev_lk, 1'b1, chk, lit, 12'(H_TOT), 12'(flines));
                if (short_line >= 0 && ln == short_line + 1 && c == 0)
                    push_ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 20'd0, 12'(H_TOT - 1), 12'd0);
                if (ln == rst_line && c == 30) begin
                    #2;
                    Reset = 1'b1;
                    #1;
                    check_all_zero("midreset");
                    pq.delete();
                    eq.delete();
                    pix_track = 1'b0;
                    lk_exp = 1'b0;
                end
                if (ln == rst_line && c == 33)
                    Reset = 1'b0;
            end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        hSync_n = 1'b1;
        vSync_n = 1'b1;
        blank_n = 1'b0;
        pixelIn = 24'd0;
        repeat (3) @(posedge Clock);
        #1;
        check_all_zero("reset");
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 24'd0, 0, 0);

        // Nominal lock on black frames
        send_frame(24, -1, 0, -1, 1'b0, 1'b0, 1'b0, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);
        // White 5x5 square
        send_frame(24, -1, 1, -1, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b1, 1'b0, 1'b1, 32'h18FFFFE7, 20'd25, 24);
        // Short line 10 -> hError, lock lost, relock after two clean vFalls
        send_frame(24, 10, 0, -1, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b0, 1'b0, 1'b0, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);
        // Short frame of 23 lines -> vError with frameDone, lock lost
        send_frame(23, -1, 0, -1, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b1, 1'b1, 1'b0, 32'd0, 20'd0, 23);
        // All-white frame: 640 * 0xFFFFFF wraps to 0x7FFFFD80
        send_frame(24, -1, 2, -1, 1'b0, 1'b0, 1'b0, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b1, 1'b0, 1'b1, 32'h7FFFFD80, 20'd640, 24);
        // Reset in the middle of an active line
        send_frame(24, -1, 0, 12, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b0, 1'b0, 1'b0, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);
        send_frame(24, -1, 0, -1, 1'b1, 1'b0, 1'b1, 32'd0, 20'd0, 24);

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 24'd0, 0, 0);
        check("pending_pixels", 32'(pq.size()), 32'd0);
        check("pending_events", 32'(eq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
